// File: rtl/puf_ctrl_pkg.sv
// Shared types and constants for the arbiter-PUF evaluation controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package puf_ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CSET   = 3'd1,
        LAUNCH = 3'd2,
        SAMPLE = 3'd3,
        RELAX  = 3'd4,
        VOTE   = 3'd5,
        DONE   = 3'd6
    } state_t;

    // x^64 + x^63 + x^61 + x^60 + 1
    localparam logic [63:0] DEF_LFSR_TAPS = 64'hD800_0000_0000_0000;

    // Cycles from request accept edge to resp_valid rising
    function automatic int puf_latency(input int resp_bits, input int settle, input int rpt);
        return resp_bits * (settle + rpt * (2 * settle + 1) + 1) + 1;
    endfunction

endpackage

// File: rtl/puf_eval_ctrl_if.sv
// Host-side request/response bundle for the PUF evaluation controller.
// Latency: n/a (wires only); optional resp_unstable under PUF_STABILITY_FLAG_EN.
// Backpressure: valid/ready on both request and response channels.
interface puf_eval_ctrl_if #(
    parameter int N_STAGES  = 64,
    parameter int RESP_BITS = 8
);
    logic                 req_valid;
    logic                 req_ready;
    logic [N_STAGES-1:0]  req_seed;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [RESP_BITS-1:0] resp_data;
`ifdef PUF_STABILITY_FLAG_EN
    logic [RESP_BITS-1:0] resp_unstable;

    modport master (output req_valid, req_seed, resp_ready,
                    input  req_ready, resp_valid, resp_data, resp_unstable);
    modport slave  (input  req_valid, req_seed, resp_ready,
                    output req_ready, resp_valid, resp_data, resp_unstable);
`else
    modport master (output req_valid, req_seed, resp_ready,
                    input  req_ready, resp_valid, resp_data);
    modport slave  (input  req_valid, req_seed, resp_ready,
                    output req_ready, resp_valid, resp_data);
`endif
endinterface

// File: rtl/puf_arb_sync.sv
// Two-flop synchronizer bringing the asynchronous arbiter decision into clk.
// Latency: 2 cycles.
// Backpressure: none.
module puf_arb_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    // Metastability filter; both stages clear to 0 on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF sequencer: expands a seed into RESP_BITS LFSR challenges, races each REPEAT times, majority-votes.
// Latency: RESP_BITS*(SETTLE + REPEAT*(2*SETTLE+1) + 1) + 1 cycles from accept to resp_valid.
// Backpressure: req_ready low from accept until the response is taken; resp_data held while resp_ready is low.
// Optional feature macro: PUF_STABILITY_FLAG_EN adds host.resp_unstable (non-unanimous sample flags).
module puf_eval_ctrl
    import puf_ctrl_pkg::*;
#(
    parameter int                  N_STAGES  = 64,
    parameter int                  RESP_BITS = 8,
    parameter int                  REPEAT    = 5,
    parameter int                  SETTLE    = 8,
    parameter logic [N_STAGES-1:0] LFSR_TAPS = N_STAGES'(DEF_LFSR_TAPS)
) (
    input  logic                clk,
    input  logic                rst,
    puf_eval_ctrl_if.slave      host,
    output logic [N_STAGES-1:0] challenge,
    output logic                launch,
    input  logic                arb_out,
    output logic                busy
);
    // Refuse to build with parameters that break the vote or the settle timing
    if ((REPEAT % 2) == 0 || REPEAT < 1 || REPEAT > 15) begin : g_bad_repeat
        $error("puf_eval_ctrl: REPEAT must be odd and within 1..15");
    end
    if (SETTLE < 3) begin : g_bad_settle
        $error("puf_eval_ctrl: SETTLE must be at least 3 to cover the synchronizer");
    end
    if (RESP_BITS < 1 || RESP_BITS > 64) begin : g_bad_resp_bits
        $error("puf_eval_ctrl: RESP_BITS must be within 1..64");
    end

    localparam int CNT_W = $clog2(SETTLE + 1);
    localparam int REP_W = $clog2(REPEAT + 1);
    localparam int IDX_W = $clog2(RESP_BITS + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [REP_W-1:0] REP_LAST    = REP_W'(REPEAT - 1);
    localparam logic [REP_W-1:0] REP_HALF    = REP_W'(REPEAT / 2);
    localparam logic [REP_W-1:0] REP_ALL     = REP_W'(REPEAT);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(RESP_BITS - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [REP_W-1:0]     rep;
    logic [REP_W-1:0]     ones;
    logic [IDX_W-1:0]     bit_idx;
    logic                 req_ready_q;
    logic                 resp_valid_q;
    logic [RESP_BITS-1:0] resp_data_q;
    logic                 arb_sync;
    logic                 vote_bit;
    logic [N_STAGES-1:0]  chal_next;

    puf_arb_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (arb_out),
        .q   (arb_sync)
    );

    assign vote_bit  = (ones > REP_HALF);
    assign chal_next = {challenge[N_STAGES-2:0], ^(challenge & LFSR_TAPS)};

`ifdef PUF_STABILITY_FLAG_EN
    logic [RESP_BITS-1:0] unst_q;
    logic                 split_vote;

    assign split_vote = (ones != '0) && (ones != REP_ALL);

    // Per-bit instability flags, cleared on accept and held through DONE like resp_data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unst_q <= '0;
        end else if (state == IDLE && host.req_valid && req_ready_q) begin
            unst_q <= '0;
        end else if (state == VOTE) begin
            unst_q <= unst_q | (RESP_BITS'(split_vote) << bit_idx);
        end
    end

    assign host.resp_unstable = unst_q;
`endif

    // Main sequencer: one challenge per CSET, REPEAT launch/sample/relax rounds, then a vote
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            challenge    <= '0;
            launch       <= 1'b0;
            busy         <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            cnt          <= '0;
            rep          <= '0;
            ones         <= '0;
            bit_idx      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (host.req_valid && req_ready_q) begin
                        // An all-zero seed would lock the LFSR, so substitute 1
                        challenge   <= (host.req_seed == '0) ? N_STAGES'(1) : host.req_seed;
                        req_ready_q <= 1'b0;
                        busy        <= 1'b1;
                        resp_data_q <= '0;
                        cnt         <= '0;
                        rep         <= '0;
                        ones        <= '0;
                        bit_idx     <= '0;
                        state       <= CSET;
                    end
                end
                CSET: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt    <= '0;
                        launch <= 1'b1;
                        state  <= LAUNCH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LAUNCH: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    ones   <= ones + REP_W'(arb_sync);
                    launch <= 1'b0;
                    state  <= RELAX;
                end
                RELAX: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt <= '0;
                        if (rep == REP_LAST) begin
                            rep   <= '0;
                            state <= VOTE;
                        end else begin
                            rep    <= rep + 1'b1;
                            launch <= 1'b1;
                            state  <= LAUNCH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                VOTE: begin
                    resp_data_q <= resp_data_q | (RESP_BITS'(vote_bit) << bit_idx);
                    ones        <= '0;
                    if (bit_idx == IDX_LAST) begin
                        state <= DONE;
                    end else begin
                        bit_idx   <= bit_idx + 1'b1;
                        challenge <= chal_next;
                        state     <= CSET;
                    end
                end
                DONE: begin
                    // First DONE cycle raises valid; afterwards wait for the host to take it
                    if (!resp_valid_q) begin
                        resp_valid_q <= 1'b1;
                    end else if (host.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign host.req_ready  = req_ready_q;
    assign host.resp_valid = resp_valid_q;
    assign host.resp_data  = resp_data_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed bench for puf_eval_ctrl with a queue scoreboard of expected responses.
// Latency: checks accept-to-valid cycle count against the closed-form formula.
// Backpressure: exercises held responses, ignored requests and back-to-back traffic.
module tb_puf_eval_ctrl;
    localparam int N  = 64;
    localparam int RB = 4;
    localparam int RP = 3;
    localparam int ST = 4;
    localparam int LAT = RB * (ST + RP * (2 * ST + 1) + 1) + 1;
    localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;

    typedef struct {
        logic [RB-1:0] data;
        logic [RB-1:0] unst;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] chal;
    logic         launch;
    logic         arb;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int arb_mode = 0;
    int base     = 0;
    int launch_cnt = 0;
    logic launch_d = 1'b0;
    int cyc = 0;
    int acc_cyc[$];
    int hs_cyc[$];
    exp_t sb[$];

    puf_eval_ctrl_if #(.N_STAGES(N), .RESP_BITS(RB)) bus ();

    puf_eval_ctrl #(.N_STAGES(N), .RESP_BITS(RB), .REPEAT(RP), .SETTLE(ST)) dut (
        .clk       (clk),
        .rst       (rst),
        .host      (bus),
        .challenge (chal),
        .launch    (launch),
        .arb_out   (arb),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Arbiter model: follow challenge[0], its inverse, or "1 during launch pulses 1 and 2 of the request"
    assign arb = (arb_mode == 0) ? chal[0] :
                 (arb_mode == 2) ? ~chal[0] :
                 (launch && ((launch_cnt - base) == 1 || (launch_cnt - base) == 2));

    always @(posedge clk) cyc <= cyc + 1;

    // Launch pulse counter and handshake log, sampled mid-cycle
    always @(negedge clk) begin
        launch_d <= launch;
        if (launch && !launch_d) launch_cnt <= launch_cnt + 1;
        if (bus.req_valid && bus.req_ready) acc_cyc.push_back(cyc);
        if (bus.resp_valid && bus.resp_ready) hs_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [63:0] seed, input int mode);
        exp_t e;
        logic [63:0] c;
        c = (seed == 64'd0) ? 64'd1 : seed;
        e.data = '0;
        e.unst = '0;
        for (int i = 0; i < RB; i++) begin
            if (mode == 0)      e.data[i] = c[0];
            else if (mode == 2) e.data[i] = ~c[0];
            else                e.data[i] = (i == 0);
            e.unst[i] = (mode == 1) && (i == 0);
            c = {c[62:0], ^(c & TAPS)};
        end
        return e;
    endfunction

    function automatic logic [63:0] last_chal(input logic [63:0] seed);
        logic [63:0] c;
        c = (seed == 64'd0) ? 64'd1 : seed;
        for (int i = 1; i < RB; i++) c = {c[62:0], ^(c & TAPS)};
        return c;
    endfunction

    // Drive one request through its accept edge; inputs change #1 after posedge
    task automatic start_req(input logic [63:0] seed, input int mode);
        int g;
        g = 0;
        while (!bus.req_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        if (!bus.req_ready) chk("req_ready_timeout", 64'd0, 64'd1);
        arb_mode      = mode;
        base          = launch_cnt;
        bus.req_seed  = seed;
        bus.req_valid = 1'b1;
        sb.push_back(model(seed, mode));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("first_chal", chal, (seed == 64'd0) ? 64'd1 : seed);
        chk("busy_after_accept", busy, 1'b1);
        chk("ready_after_accept", bus.req_ready, 1'b0);
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (bus.resp_valid) break;
        end
        if (!bus.resp_valid) chk("resp_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_resp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_data"}, bus.resp_data, e.data);
`ifdef PUF_STABILITY_FLAG_EN
            chk({tag, "_unst"}, bus.resp_unstable, e.unst);
`endif
        end
    endtask

    task automatic take_resp();
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        int n;
        int g;
        int a0;
        int h0;
        logic [RB-1:0] held;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_seed  = '0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_resp_data", bus.resp_data, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_launch", launch, 1'b0);
        chk("rst_chal", chal, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a LAUNCH window
        start_req(64'h1, 0);
        void'(sb.pop_back());
        g = 0;
        while (!launch && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        chk("launch_seen", launch, 1'b1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_launch", launch, 1'b0);
        chk("midrst_req_ready", bus.req_ready, 1'b1);
        chk("midrst_resp_valid", bus.resp_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Seed 1 with arb = challenge[0]: latency, data, launch count
        start_req(64'h1, 0);
        wait_resp(n);
        chk("latency_seed1", 64'(n), 64'(LAT));
        check_resp("seed1");
        chk("launch_cnt_seed1", 64'(launch_cnt - base), 64'(RB * RP));
        take_resp();

        // Seed 0 must behave as seed 1
        start_req(64'h0, 0);
        wait_resp(n);
        chk("latency_seed0", 64'(n), 64'(LAT));
        check_resp("seed0");
        take_resp();

        // Seed with the top tap bit set so the feedback bit is exercised
        start_req(64'h8000_0000_0000_0001, 0);
        wait_resp(n);
        check_resp("seed_msb");
        take_resp();

        // Inverted arbiter
        start_req(64'h1, 2);
        wait_resp(n);
        check_resp("inverted");
        take_resp();

        // 2-of-3 ones on bit 0 only
        start_req(64'h1, 1);
        wait_resp(n);
        check_resp("majority");
        take_resp();

        // Response held under backpressure; stray requests ignored
        start_req(64'h1, 0);
        wait_resp(n);
        check_resp("hold");
        held = bus.resp_data;
        chk("chal_hold", chal, last_chal(64'h1));
        for (int i = 0; i < 20; i++) begin
            bus.req_valid = (i % 2 == 0);
            @(posedge clk); #1;
            chk("hold_valid", bus.resp_valid, 1'b1);
            chk("hold_data", bus.resp_data, held);
            chk("hold_ready", bus.req_ready, 1'b0);
        end
        bus.req_valid = 1'b0;
        take_resp();
        chk("release_valid", bus.resp_valid, 1'b0);
        chk("release_req_ready", bus.req_ready, 1'b1);
        chk("release_busy", busy, 1'b0);

        // Back-to-back with resp_ready tied high and req_valid held
        arb_mode = 0;
        a0 = acc_cyc.size();
        h0 = hs_cyc.size();
        bus.resp_ready = 1'b1;
        bus.req_seed   = 64'h1;
        bus.req_valid  = 1'b1;
        base = launch_cnt;
        sb.push_back(model(64'h1, 0));
        sb.push_back(model(64'h1, 0));
        for (int r = 0; r < 2; r++) begin
            wait_resp(n);
            check_resp("b2b");
            chk("b2b_launch_cnt", 64'(launch_cnt - base), 64'(RB * RP));
            if (r == 1) bus.req_valid = 1'b0;
            @(posedge clk); #1;
            chk("b2b_one_cycle_valid", bus.resp_valid, 1'b0);
            base = launch_cnt;
        end
        bus.resp_ready = 1'b0;
        @(posedge clk); #1;
        if (acc_cyc.size() >= a0 + 2 && hs_cyc.size() >= h0 + 1)
            chk("b2b_accept_after_hs", 64'(acc_cyc[a0 + 1] > hs_cyc[h0]), 64'd1);
        else
            chk("b2b_handshake_log", 64'd0, 64'd1);
        chk("b2b_idle_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/puf_eval_ctrl.md
Name: puf_eval_ctrl

Overview:
Sequencer for the 64-stage arbiter PUF delay chain (chain of 1-challenge-bit crossbar stages terminated by an arbiter).
- Accepts a seed challenge from the host and expands it with an LFSR into RESP_BITS challenges.
- For each challenge: drives it onto the chain, launches the race pulse, samples the arbiter REPEAT times, and majority-votes one response bit.
- Sits between the AES key-generation logic (host) and the PUF fabric.

Parameters:
- N_STAGES, 64, challenge width = number of delay stages.
- RESP_BITS, 8, response bits (challenges) per request; range 1..64.
- REPEAT, 5, evaluations per challenge; must be odd, range 1..15.
- SETTLE, 8, wait cycles for challenge/launch/relax settling; must be ≥3 to cover synchronizer latency.
- LFSR_TAPS, 64'hD800_0000_0000_0000, feedback mask (x^64+x^63+x^61+x^60+1).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- req_valid, input, 1, host request.
- req_ready, output, 1, controller idle and accepting.
- req_seed, input, N_STAGES, first challenge.
- challenge, output, N_STAGES, to PUF stage select inputs.
- launch, output, 1, race pulse into both chain inputs.
- arb_out, input, 1, asynchronous arbiter result.
- resp_valid, output, 1, response available.
- resp_ready, input, 1, host accepts response.
- resp_data, output, RESP_BITS, voted response.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset (async): state=IDLE; challenge=0, launch=0, resp_valid=0, resp_data=0, busy=0, req_ready=1; counters and synchronizer cleared. Reset mid-operation drops launch immediately and discards partial results.
- arb_out passes through a 2-FF synchronizer; the sampled value is the synchronizer output.
- Request accept: req_valid&&req_ready at edge E0.
  - Seed latched; seed 0 is replaced by 1.
  - req_ready=0 from E0 until the response is accepted.
  - req_valid while not ready is ignored.
- States:
  - IDLE: waits for accept, then goes to CSET.
  - CSET (SETTLE cycles): challenge driven, launch=0.
  - LAUNCH (SETTLE cycles): launch=1.
  - SAMPLE (1 cycle): launch=1; ones counter += synced bit.
  - RELAX (SETTLE cycles): launch=0. Goes to LAUNCH if repeats remain, else VOTE.
  - VOTE (1 cycle): bit = (ones > REPEAT/2); written into resp_data[bit_idx]; ones cleared. If bit_idx == RESP_BITS-1, go to DONE; otherwise bit_idx+1, challenge = {challenge[N-2:0], ^(challenge & LFSR_TAPS)}, go to CSET.
  - DONE: resp_valid=1; resp_data stable while valid. On resp_valid&&resp_ready: resp_valid=0, go to IDLE, req_ready=1 next cycle.
- Ordering: resp_data[0] comes from the seed challenge. challenge holds its last value after DONE.
- Latency: resp_valid rises exactly RESP_BITS*(SETTLE + REPEAT*(2*SETTLE+1) + 1) + 1 cycles after E0.
- Boundaries:
  - resp_ready held high in DONE gives 1-cycle valid.
  - A new request is not accepted in the same cycle the response is taken.
  - Counters sized with $clog2 and do not wrap within legal parameter ranges.
  - Illegal parameters (even REPEAT, SETTLE<3) stop elaboration via generate error.

Optional Feature:
PUF_STABILITY_FLAG_EN
- Defined:
  - Adds output resp_unstable[RESP_BITS-1:0].
  - A bit is set when its REPEAT samples were not unanimous (0 < ones < REPEAT).
  - Valid, held and reset like resp_data.
- Undefined: port absent; no extra logic.

Decomposition:
- Package puf_ctrl_pkg holds:
  - state encoding constants (IDLE, CSET, LAUNCH, SAMPLE, RELAX, VOTE, DONE);
  - default LFSR_TAPS;
  - a latency-formula function for the bench.
- Sub-module puf_arb_sync: 2-FF synchronizer with async active-high reset to 0.

Test Plan:
- Reset mid-LAUNCH (SETTLE=4, REPEAT=3, RESP_BITS=4): assert rst → launch=0 same cycle; req_ready=1, resp_valid=0, busy=0.
- Model arb_out = challenge[0]; seed=64'h1, SETTLE=4, REPEAT=3, RESP_BITS=4 → resp_valid exactly 129 cycles after E0; resp_data=4'b0001 (challenges 1,2,4,8).
- Seed=0 → first challenge driven = 64'h1; result identical to the seed=1 case.
- arb_out forced 1 for 2 of 3 samples of bit 0, else 0 → resp_data[0]=1. With PUF_STABILITY_FLAG_EN: resp_unstable=4'b0001.
- resp_ready held low 20 cycles in DONE → resp_valid and resp_data stable; req_valid pulses ignored (req_ready=0). Then resp_ready=1 → IDLE next cycle.
- Back-to-back requests with resp_ready tied high → second accept no earlier than one cycle after the first response handshake; launch pulse count per request = RESP_BITS*REPEAT = 12.
